// File: rtl/wb_region_mux.sv
// Wishbone address-region demux: decodes one master request to one of NSLV slave channels
// (or a default channel), forwards it registered, and returns ack/data or a timeout error.
module wb_region_mux #(
    parameter int unsigned          NSLV        = 2,
    parameter int unsigned          DW          = 32,
    parameter logic [NSLV*32-1:0]   REGION_BASE = {32'h0340_0000, 32'h0330_0000},
    parameter logic [NSLV*32-1:0]   REGION_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int unsigned          TIMEOUT     = 255,
    parameter logic [31:0]          ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                   sys_clk,
    input  logic                   reset_n,
    input  logic [31:0]            m_adr,
    input  logic [DW-1:0]          m_dat_w,
    input  logic [DW/8-1:0]        m_sel,
    input  logic                   m_we,
    input  logic                   m_cyc,
    input  logic                   m_stb,
    output logic [DW-1:0]          m_dat_r,
    output logic                   m_ack,
    output logic                   m_err,
    output logic [31:0]            s_adr,
    output logic [DW-1:0]          s_dat_w,
    output logic [DW/8-1:0]        s_sel,
    output logic                   s_we,
    output logic [NSLV:0]          s_stb,
    input  logic [NSLV:0]          s_ack,
    input  logic [(NSLV+1)*DW-1:0] s_dat_r,
    output logic [7:0]             err_cnt
);

    localparam int unsigned       CW        = $clog2(NSLV + 1);
    localparam logic [15:0]       TimerLast = 16'(TIMEOUT - 1);
    localparam logic [DW-1:0]     ErrData   = DW'(ERR_DATA);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   chan_q, chan_d, dec_chan;
    logic [15:0]     timer_q, timer_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [DW-1:0]   dat_r_q, dat_r_d;
    logic [31:0]     adr_q, adr_d;
    logic [DW-1:0]   dat_w_q, dat_w_d;
    logic [DW/8-1:0] sel_q, sel_d;
    logic            we_q, we_d;
    logic            sel_ack;
    logic [DW-1:0]   sel_dat;

    // Walk downwards so the lowest-numbered hitting region overrides the rest.
    always_comb begin
        dec_chan = CW'(NSLV);
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            if ((m_adr & REGION_MASK[i*32 +: 32]) == REGION_BASE[i*32 +: 32]) begin
                dec_chan = CW'(i);
            end
        end
    end

    assign sel_ack = s_ack[chan_q];
    assign sel_dat = s_dat_r[int'(chan_q)*DW +: DW];

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        timer_d   = timer_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        dat_r_d   = dat_r_q;
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        sel_d     = sel_q;
        we_d      = we_q;
        unique case (state_q)
            StIdle: begin
                if (m_cyc && m_stb && !m_ack && !m_err) begin
                    adr_d   = m_adr;
                    dat_w_d = m_dat_w;
                    sel_d   = m_sel;
                    we_d    = m_we;
                    chan_d  = dec_chan;
                    timer_d = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Abort beats a coincident ack; ack beats a coincident timeout.
                if (!m_cyc) begin
                    state_d = StIdle;
                end else if (sel_ack) begin
                    dat_r_d = sel_dat;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (timer_q == TimerLast) begin
                    dat_r_d = ErrData;
                    err_d   = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = StResp;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            chan_q    <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            dat_r_q   <= '0;
            adr_q     <= '0;
            dat_w_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            dat_r_q   <= dat_r_d;
            adr_q     <= adr_d;
            dat_w_q   <= dat_w_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
        end
    end

    always_comb begin
        s_stb = '0;
        if (state_q == StReq) begin
            s_stb[chan_q] = 1'b1;
        end
    end

    assign m_ack   = (state_q == StResp) && !err_q;
    assign m_err   = (state_q == StResp) && err_q;
    assign m_dat_r = dat_r_q;
    assign s_adr   = adr_q;
    assign s_dat_w = dat_w_q;
    assign s_sel   = sel_q;
    assign s_we    = we_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_wb_region_mux.sv
// Bench for wb_region_mux: directed and randomized transactions against a transaction-level
// model of region decode, slave wait/timeout behaviour and the saturating error counter.
module tb_wb_region_mux;

    localparam int TMO = 4;
    localparam logic [31:0] BASE [2] = '{32'h0330_0000, 32'h0340_0000};
    localparam logic [31:0] MASK [2] = '{32'hFFFF_0000, 32'hFFFF_0000};

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic [31:0] m_adr, m_dat_w, m_dat_r, s_adr, s_dat_w;
    logic [3:0]  m_sel, s_sel;
    logic        m_we, m_cyc, m_stb, m_ack, m_err, s_we;
    logic [2:0]  s_stb, s_ack;
    logic [95:0] s_dat_r;
    logic [7:0]  err_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_cnt = 0;
    logic [31:0] exp_last = '0;

    wb_region_mux #(
        .NSLV(2), .DW(32), .TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_we(m_we),
        .m_cyc(m_cyc), .m_stb(m_stb),
        .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_we(s_we),
        .s_stb(s_stb), .s_ack(s_ack), .s_dat_r(s_dat_r),
        .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 2; i++) begin
            if ((a & MASK[i]) == BASE[i]) return i;
        end
        return 2;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".s_stb"}, 64'(s_stb), 64'd0);
        check({tag, ".m_ack"}, 64'(m_ack), 64'd0);
        check({tag, ".m_err"}, 64'(m_err), 64'd0);
        check({tag, ".err_cnt"}, 64'(err_cnt), 64'd0);
        check({tag, ".m_dat_r"}, 64'(m_dat_r), 64'd0);
        check({tag, ".s_adr"}, 64'(s_adr), 64'd0);
        check({tag, ".s_dat_w"}, 64'(s_dat_w), 64'd0);
        check({tag, ".s_sel"}, 64'(s_sel), 64'd0);
        check({tag, ".s_we"}, 64'(s_we), 64'd0);
    endtask

    // Called at a negedge with the DUT idle; waits < 0 means the slave never acks.
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       input logic [3:0] sel, input int waits);
        int          ch;
        int          last;
        logic        tmo;
        logic [2:0]  oh;
        logic [31:0] sdat [3];
        logic [31:0] exp_dat;
        ch   = decode(adr);
        oh   = 3'(1 << ch);
        tmo  = (waits < 0) || (waits >= TMO);
        last = tmo ? TMO - 1 : waits;
        for (int k = 0; k < 3; k++) sdat[k] = $urandom;
        s_dat_r = {sdat[2], sdat[1], sdat[0]};
        exp_dat = tmo ? 32'hDEAD_BEEF : sdat[ch];
        m_adr = adr; m_we = we; m_dat_w = wdat; m_sel = sel;
        m_cyc = 1'b1; m_stb = 1'b1; s_ack = '0;
        for (int c = 0; c <= last; c++) begin
            @(negedge sys_clk);
            check("s_stb", 64'(s_stb), 64'(oh));
            check("s_adr", 64'(s_adr), 64'(adr));
            check("s_dat_w", 64'(s_dat_w), 64'(wdat));
            check("s_sel", 64'(s_sel), 64'(sel));
            check("s_we", 64'(s_we), 64'(we));
            check("no_early_resp", 64'({m_ack, m_err}), 64'd0);
            // Master wiggles its inputs; stray acks come from unselected channels.
            m_adr = $urandom; m_dat_w = $urandom; m_we = ~we; m_sel = 4'($urandom);
            s_ack = (3'($urandom) & ~oh) | ((c == waits) ? oh : 3'b000);
        end
        @(negedge sys_clk);
        s_ack = '0;
        if (tmo && exp_cnt < 255) exp_cnt++;
        exp_last = exp_dat;
        check("m_ack", 64'(m_ack), 64'(!tmo));
        check("m_err", 64'(m_err), 64'(tmo));
        check("m_dat_r", 64'(m_dat_r), 64'(exp_dat));
        check("resp_stb", 64'(s_stb), 64'd0);
        check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge sys_clk);
        check("pulse_end", 64'({m_ack, m_err}), 64'd0);
        check("dat_hold", 64'(m_dat_r), 64'(exp_last));
    endtask

    initial begin
        reset_n = 1'b0;
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = '0; s_dat_r = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;

        // Zero-wait read, waited write (ack on the timeout-limit cycle), unmapped read.
        txn(32'h0330_0004, 1'b0, 32'h0, 4'hF, 0);
        txn(32'h0340_0010, 1'b1, 32'hA5A5_A5A5, 4'hF, 3);
        txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1);
        txn(32'h0330_0000, 1'b0, 32'h0, 4'hF, -1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 2);
            a = (r == 0) ? {16'h0330, 16'($urandom)} :
                (r == 1) ? {16'h0340, 16'($urandom)} : 32'($urandom);
            txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5));
        end

        // Abort two cycles into the request.
        m_adr = 32'h0340_0000; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1; s_ack = '0;
        @(negedge sys_clk);
        check("abort_stb0", 64'(s_stb), 64'd2);
        @(negedge sys_clk);
        check("abort_stb1", 64'(s_stb), 64'd2);
        m_cyc = 1'b0; m_stb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            check("abort_stb_low", 64'(s_stb), 64'd0);
            check("abort_no_resp", 64'({m_ack, m_err}), 64'd0);
            check("abort_err_cnt", 64'(err_cnt), 64'(exp_cnt));
        end

        // Saturate the error counter.
        for (int n = 0; n < 300; n++) txn(32'h0330_0000, 1'b0, 32'h0, 4'hF, -1);
        check("err_cnt_sat", 64'(err_cnt), 64'd255);

        // Asynchronous reset in the middle of a request.
        m_adr = 32'h0340_0020; m_dat_w = 32'h1111_2222; m_sel = 4'h3; m_we = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(negedge sys_clk);
        check("pre_reset_stb", 64'(s_stb), 64'd2);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_cnt = 0;
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge sys_clk);
        reset_n = 1'b1;
        txn(32'h0330_0008, 1'b0, 32'h0, 4'hF, 2);
        txn(32'h0340_0008, 1'b1, 32'hCAFE_F00D, 4'h5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_region_mux.md
WB_REGION_MUX -- requirements
Module: wb_region_mux

Interface
REQ-001 SHALL have parameter NSLV, default 2, number of decoded slave regions (1..8); channel index NSLV is the default/unmapped route.
REQ-002 SHALL have parameter DW, default 32, data width (multiple of 8); AW fixed at 32.
REQ-003 SHALL have parameter REGION_BASE, default {32'h0340_0000, 32'h0330_0000}, packed NSLV*32 base addresses, region 0 in LSBs.
REQ-004 SHALL have parameter REGION_MASK, default {32'hFFFF_0000, 32'hFFFF_0000}, packed NSLV*32 compare masks.
REQ-005 SHALL have parameter TIMEOUT, default 255, slave cycles allowed before bus error (1..65535).
REQ-006 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on error (low DW bits).
REQ-007 sys_clk  in  1  sole clock, rising edge.
REQ-008 reset_n  in  1  reset, asynchronous, active-low.
REQ-009 m_adr / m_dat_w / m_sel  in  32 / DW / DW/8  master address, write data, byte selects.
REQ-010 m_we / m_cyc / m_stb  in  1 each  master write, cycle, strobe.
REQ-011 m_dat_r / m_ack / m_err  out  DW / 1 / 1  read data, 1-cycle ack pulse, 1-cycle error pulse.
REQ-012 s_adr / s_dat_w / s_sel / s_we  out  32 / DW / DW/8 / 1  registered request broadcast to all slaves.
REQ-013 s_stb  out  NSLV+1  one-hot per-channel strobe; bit NSLV = default channel.
REQ-014 s_ack  in  NSLV+1  per-channel ack; s_dat_r  in  (NSLV+1)*DW  per-channel read data, channel 0 in LSBs.
REQ-015 err_cnt  out  8  saturating count of timeouts.

Function
REQ-016 Decode: hit_i = ((m_adr & MASK_i) == BASE_i); lowest hitting index wins; no hit selects channel NSLV.
REQ-017 FSM states IDLE, REQ, RESP; reset state IDLE.
REQ-018 IDLE: on m_cyc & m_stb & !m_ack & !m_err, latch m_adr/m_dat_w/m_sel/m_we into s_*, latch channel index, clear timer, go REQ.
REQ-019 REQ: s_stb[chan] = 1, all other s_stb bits 0; s_stb is 0 in IDLE and RESP.
REQ-020 REQ: on s_ack[chan] = 1, register s_dat_r[chan] into m_dat_r (reads and writes alike), go RESP with ack flag.
REQ-021 REQ: s_ack of unselected channels SHALL be ignored.
REQ-022 REQ: timer increments each cycle without ack; when timer == TIMEOUT-1 with no ack, m_dat_r = ERR_DATA, go RESP with error flag, err_cnt += 1 saturating at 255.
REQ-023 Ack on the same cycle as the timeout limit SHALL win (no error).
REQ-024 RESP: assert exactly one of m_ack/m_err for one cycle, then IDLE; m_dat_r holds until the next response.
REQ-025 Latency: request sampled cycle N; s_stb high from cycle N+1; zero-wait slave acks cycle N+1; m_ack cycle N+2; back-to-back accept no earlier than cycle N+3.
REQ-026 Abort: m_cyc = 0 while in REQ -> drop s_stb next cycle, go IDLE, no m_ack/m_err, err_cnt unchanged.
REQ-027 Address, data and channel SHALL NOT change during REQ even if master inputs change.

Reset
REQ-028 reset_n low SHALL immediately clear state to IDLE, and s_stb, m_ack, m_err, err_cnt, timer, m_dat_r, s_adr, s_dat_w, s_sel and s_we to 0, including mid-transaction.
REQ-029 After reset_n rises, first request SHALL be accepted on the first rising edge with m_cyc & m_stb.

Verification
REQ-030 Read 0x0330_0004, s_ack[0] same cycle as s_stb[0], s_dat_r[0]=0x1234_5678 -> s_stb=3'b001 one cycle, m_ack one cycle later, m_dat_r=0x1234_5678.
REQ-031 Write 0x0340_0010 data 0xA5A5_A5A5 sel 4'hF, s_ack[1] after 3 wait cycles -> s_stb=3'b010 for 4 cycles, s_dat_w=0xA5A5_A5A5, s_we=1, m_ack once.
REQ-032 Read 0x0000_0100 (unmapped) -> s_stb=3'b100, data from s_dat_r[2] returned with m_ack.
REQ-033 TIMEOUT=4, read 0x0330_0000, s_ack never -> s_stb high 4 cycles, m_err one cycle, m_dat_r=0xDEAD_BEEF, err_cnt=1; 300 timeouts -> err_cnt=255.
REQ-034 m_cyc dropped 2 cycles into REQ -> s_stb low next cycle, no m_ack/m_err; reset_n pulsed low mid-REQ -> all outputs 0 asynchronously, next request served normally.
